iddmm_mul_arbiter: RTL

Round-robin scheduler that shares one fully pipelined 128x128 multiplier between `NUM_REQ` requesters in the Montgomery datapath. It accepts at most one operand pair per cycle, tags it with the requester index, and tracks the tag through the multiplier's fixed-latency pipeline. Each 256-bit product is returned on a broadcast result bus with the matching index. It sits between the IDDMM iteration controllers and the shared `iddmm_mul_128_to_256` instance, which it instantiates.

---
 rtl/iddmm_pkg.sv | 31 +++
 rtl/iddmm_mul_arbiter_if.sv | 43 ++++
 rtl/iddmm_mul_128_to_256.sv | 40 ++++
 rtl/iddmm_rr_arb.sv | 61 ++++++
 rtl/iddmm_mul_arbiter.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/iddmm_pkg.sv
// -----------------------------------------------------------------------------
// iddmm_pkg
// Shared constants and types for the IDDMM Montgomery datapath.
//   MUL_W        operand width of the shared multiplier
//   PROD_W       product width of the shared multiplier
//   MUL_LAT_DEF  register stages of the shared multiplier. Controllers use this
//                value to predict the cycle a product returns.
//   TAG_ID_W     index width of a tag; wide enough for the 16 requesters allowed
//   mul_tag_t    tag that travels alongside an operation: valid + requester index
// -----------------------------------------------------------------------------
package iddmm_pkg;

    localparam int MUL_W       = 128;
    localparam int PROD_W      = 256;
    localparam int MUL_LAT_DEF = 6;
    localparam int TAG_ID_W    = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } mul_tag_t;

    // Idle slots carry index 0 so that empty tags are all-zero.
    function automatic mul_tag_t make_tag(input logic valid, input logic [TAG_ID_W-1:0] id);
        mul_tag_t t;
        t.valid = valid;
        t.id    = valid ? id : {TAG_ID_W{1'b0}};
        return t;
    endfunction

endpackage

// File: rtl/iddmm_mul_arbiter_if.sv
// -----------------------------------------------------------------------------
// iddmm_mul_arbiter_if
// Bundle between the IDDMM iteration controllers (master) and the shared
// multiplier scheduler (slave).
//   issue_en        master->slave  allow new grants
//   req_valid       master->slave  per-requester operand pair valid
//   req_x, req_y    master->slave  packed operands, requester i at [128*i +: 128]
//   req_ready       slave->master  one-hot grant
//   res_valid       slave->master  product valid this cycle (no backpressure)
//   res_id          slave->master  requester index of the product
//   res_data        slave->master  256-bit product
//   busy            slave->master  at least one operation in flight
//   perf_issue_cnt  slave->master  issued-operation counter
// -----------------------------------------------------------------------------
interface iddmm_mul_arbiter_if
    import iddmm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);

    logic                     issue_en;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*MUL_W-1:0] req_x;
    logic [NUM_REQ*MUL_W-1:0] req_y;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     res_valid;
    logic [ID_W-1:0]          res_id;
    logic [PROD_W-1:0]        res_data;
    logic                     busy;
    logic [31:0]              perf_issue_cnt;

    modport master (
        output issue_en, req_valid, req_x, req_y,
        input  req_ready, res_valid, res_id, res_data, busy, perf_issue_cnt
    );

    modport slave (
        input  issue_en, req_valid, req_x, req_y,
        output req_ready, res_valid, res_id, res_data, busy, perf_issue_cnt
    );

endinterface

// File: rtl/iddmm_mul_128_to_256.sv
// -----------------------------------------------------------------------------
// iddmm_mul_128_to_256
// Fully pipelined 128x128 -> 256 multiplier with MUL_LAT register stages
// between its inputs and the result. It accepts a new operand pair every cycle.
//   clk    clock
//   rst_n  synchronous active-low reset; clears the pipeline
//   a, b   operands
//   p      product a*b, MUL_LAT cycles after a/b are presented
// -----------------------------------------------------------------------------
module iddmm_mul_128_to_256
    import iddmm_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MUL_W-1:0]  a,
    input  logic [MUL_W-1:0]  b,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] pipe_r [MUL_LAT];

    // Product pipeline: stage 0 holds a*b, and later stages delay it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= PROD_W'(a) * PROD_W'(b);
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign p = pipe_r[MUL_LAT-1];

endmodule

// File: rtl/iddmm_rr_arb.sv
// -----------------------------------------------------------------------------
// iddmm_rr_arb
// Combinational round-robin arbiter with a registered last-grant pointer.
// Priority starts one past the last granted index and wraps modulo NUM_REQ.
// After reset the pointer is NUM_REQ-1, so index 0 has first priority.
//   clk       clock
//   rst       synchronous active-high reset; forces grant to zero
//   req       request vector
//   en        global enable; when low, no grant is issued
//   grant     one-hot grant (combinational)
//   grant_id  encoded index of the grant (0 when there is no grant)
// -----------------------------------------------------------------------------
module iddmm_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0]    ptr_r;
    logic [NUM_REQ-1:0] req_m_s;
    logic [ID_W-1:0]    idx_s;
    logic               found_s;

    assign req_m_s = req & {NUM_REQ{en & ~rst}};

    // Scan from ptr+1 around the ring; the first active request wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found_s  = 1'b0;
        idx_s    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = ID_W'((int'(ptr_r) + k) % NUM_REQ);
            if (!found_s && req_m_s[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_id     = idx_s;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Last-grant pointer; moves only when something is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= ID_W'(NUM_REQ - 1);
        end else if (found_s) begin
            ptr_r <= grant_id;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/iddmm_mul_arbiter.sv
// -----------------------------------------------------------------------------
// iddmm_mul_arbiter
// Shares one pipelined 128x128 multiplier between NUM_REQ requesters. It
// grants at most one operand pair per cycle (round-robin) and registers the
// granted operands into the multiplier inputs. A tag {valid, id} travels
// alongside each operation, so the product returns MUL_LAT+1 cycles after
// acceptance with its requester index attached.
//   clk   clock
//   rst   synchronous active-high reset; in-flight operations are dropped
//   bus   iddmm_mul_arbiter_if.slave (request side, result side, busy, perf)
// Optional feature macro: IDDMM_MUL_ARB_PERF_EN. When defined, a saturating
// 32-bit grant counter drives perf_issue_cnt. When undefined, the port is
// tied to zero.
// -----------------------------------------------------------------------------
module iddmm_mul_arbiter
    import iddmm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst,
    iddmm_mul_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    grant_id_s;
    logic               grant_vld_s;
    logic [MUL_W-1:0]   x_sel_s;
    logic [MUL_W-1:0]   y_sel_s;
    logic [MUL_W-1:0]   x_r;
    logic [MUL_W-1:0]   y_r;
    logic [PROD_W-1:0]  prod_s;
    logic               rst_n_s;
    mul_tag_t           tag_sr_r [MUL_LAT];
    logic               res_valid_r;
    logic [ID_W-1:0]    res_id_r;
    logic               busy_s;

    iddmm_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.req_valid),
        .en       (bus.issue_en),
        .grant    (grant_s),
        .grant_id (grant_id_s)
    );

    assign grant_vld_s   = |grant_s;
    assign bus.req_ready = grant_s;

    // One-hot AND-OR operand mux; the grant selects exactly one slice.
    always_comb begin
        x_sel_s = '0;
        y_sel_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            x_sel_s = x_sel_s | (bus.req_x[MUL_W*i +: MUL_W] & {MUL_W{grant_s[i]}});
            y_sel_s = y_sel_s | (bus.req_y[MUL_W*i +: MUL_W] & {MUL_W{grant_s[i]}});
        end
    end

    // Multiplier input registers; loaded only on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r <= '0;
            y_r <= '0;
        end else if (grant_vld_s) begin
            x_r <= x_sel_s;
            y_r <= y_sel_s;
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

    assign rst_n_s = ~rst;

    iddmm_mul_128_to_256 #(
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n_s),
        .a     (x_r),
        .b     (y_r),
        .p     (prod_s)
    );

    assign bus.res_data = prod_s;

    // The tag shift register is MUL_LAT deep. One more output stage lines the
    // tag up with the product, which is one input register plus MUL_LAT
    // multiplier stages away.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_sr_r[i] <= '0;
            end
            res_valid_r <= 1'b0;
            res_id_r    <= '0;
        end else begin
            tag_sr_r[0] <= make_tag(grant_vld_s, TAG_ID_W'(grant_id_s));
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_sr_r[i] <= tag_sr_r[i-1];
            end
            res_valid_r <= tag_sr_r[MUL_LAT-1].valid;
            res_id_r    <= tag_sr_r[MUL_LAT-1].id[ID_W-1:0];
        end
    end

    // busy is the OR of the valid bits in the tag shift register.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            busy_s = busy_s | tag_sr_r[i].valid;
        end
    end

    assign bus.res_valid = res_valid_r;
    assign bus.res_id    = res_id_r;
    assign bus.busy      = busy_s;

`ifdef IDDMM_MUL_ARB_PERF_EN
    logic [31:0] perf_cnt_r;

    // Grant counter; it saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_r <= 32'h0000_0000;
        end else if (grant_vld_s && (perf_cnt_r != 32'hFFFF_FFFF)) begin
            perf_cnt_r <= perf_cnt_r + 32'h0000_0001;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign bus.perf_issue_cnt = perf_cnt_r;
`else
    assign bus.perf_issue_cnt = 32'h0000_0000;
`endif

endmodule
